// File: rtl/pipe_equal_pkg.sv
// Shared helpers for the pipelined equality comparator.
// Latency: n/a (compile-time helpers only).
// Backpressure: n/a.
package pipe_equal_pkg;

    // Number of slices needed to cover n bits in d-bit pieces.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/pipe_equal.sv
// Pipelined bitwise equality of two WIDTH-bit operands, split into CHUNK-bit slices.
// Latency: eq after edge n+2 reflects (a==b) sampled at edge n; 3 register levels.
// Backpressure: none; accepts a new pair every cycle, never stalls.
module pipe_equal
    import pipe_equal_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    localparam int NCHUNK = ceil_div(WIDTH, CHUNK);

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    // Marks stage-1 contents as real data rather than cleared reset values;
    // without it the cleared (and therefore equal) operands would report eq=1.
    logic              s1_live;
    logic [NCHUNK-1:0] slice_eq;
    logic [NCHUNK-1:0] flag_q;

    // Stage 1: capture operands every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s1_live <= 1'b0;
        end else begin
            a_q     <= a;
            b_q     <= b;
            s1_live <= 1'b1;
        end
    end

    // Per-slice compare; the top slice is clipped to the valid operand bits.
    for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
        localparam int LO = i * CHUNK;
        localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
        assign slice_eq[i] = s1_live && (a_q[HI:LO] == b_q[HI:LO]);
    end

    // Stage 2: register one equality flag per slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= slice_eq;
        end
    end

    // Stage 3: overall result is the AND of all slice flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            eq <= 1'b0;
        end else begin
            eq <= &flag_q;
        end
    end

endmodule

// File: tb/tb_pipe_equal.sv
module tb_pipe_equal;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        eq;
    logic [19:0] a2;
    logic [19:0] b2;
    logic        eq2;

    int checks = 0;
    int errors = 0;

    // History of every edge: reset level and whether the pair was equal.
    bit rst_h[$];
    bit pair_h[$];
    bit pair2_h[$];

    always #5 clk = ~clk;

    pipe_equal #(.WIDTH(64), .CHUNK(8)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .eq  (eq)
    );

    pipe_equal #(.WIDTH(20), .CHUNK(8)) dut20 (
        .clk (clk),
        .rst (rst),
        .a   (a2),
        .b   (b2),
        .eq  (eq2)
    );

    // Reference: result after edge k is the pair sampled at edge k-2,
    // provided no reset was seen at edges k-2, k-1 or k.
    function automatic bit expect_at(input int k, input bit narrow);
        bit p;
        if (k < 2) return 1'b0;
        if (rst_h[k] || rst_h[k-1] || rst_h[k-2]) return 1'b0;
        p = narrow ? pair2_h[k-2] : pair_h[k-2];
        return p;
    endfunction

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [63:0] av, input logic [63:0] bv,
                        input logic [19:0] a2v, input logic [19:0] b2v,
                        output logic e, output logic e2);
        int k;
        rst = r;
        a   = av;
        b   = bv;
        a2  = a2v;
        b2  = b2v;
        rst_h.push_back(r);
        pair_h.push_back(av == bv);
        pair2_h.push_back(a2v == b2v);
        @(posedge clk);
        #1;
        k = rst_h.size() - 1;
        check($sformatf("model64 edge%0d", k), eq, expect_at(k, 1'b0));
        check($sformatf("model20 edge%0d", k), eq2, expect_at(k, 1'b1));
        e  = eq;
        e2 = eq2;
    endtask

    typedef struct {
        logic        r;
        logic [63:0] av;
        logic [63:0] bv;
        logic        exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic        e;
        logic        e2;
        logic [63:0] x;
        logic [63:0] y;
        logic [19:0] x2;
        logic [19:0] y2;
        int          sel;

        rst = 1'b1;
        a   = '0;
        b   = '0;
        a2  = '0;
        b2  = '0;

        // Directed table: exp is eq expected right after that row's edge.
        tbl[0]  = '{1'b1, 64'h0,                    64'h0,                    1'b0};
        tbl[1]  = '{1'b1, 64'hDEAD_BEEF_0000_1111,  64'hDEAD_BEEF_0000_1111,  1'b0};
        tbl[2]  = '{1'b0, 64'h0123_4567_89AB_CDEF,  64'h0123_4567_89AB_CDEF,  1'b0};
        tbl[3]  = '{1'b0, 64'h8000_0000_0000_0000,  64'h0,                    1'b0};
        tbl[4]  = '{1'b0, 64'h1,                    64'h0,                    1'b1};
        tbl[5]  = '{1'b0, 64'h0,                    64'h0,                    1'b0};
        tbl[6]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF,  1'b0};
        tbl[7]  = '{1'b0, 64'h5555_5555_5555_5555,  64'h5555_5555_5555_5555,  1'b1};
        tbl[8]  = '{1'b0, 64'h5555_5555_5555_5555,  64'h5555_5555_5555_5554,  1'b1};
        tbl[9]  = '{1'b0, 64'h0,                    64'h0,                    1'b1};
        tbl[10] = '{1'b0, 64'h0,                    64'h0,                    1'b0};
        tbl[11] = '{1'b0, 64'h0,                    64'h0,                    1'b1};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].av, tbl[i].bv, tbl[i].av[19:0], tbl[i].bv[19:0], e, e2);
            check($sformatf("table row%0d", i), e, tbl[i].exp);
        end

        // Back-to-back alternation of equal and unequal pairs.
        for (int i = 0; i < 16; i++) begin
            x = {$urandom, $urandom};
            y = (i % 2 == 0) ? x : (x ^ 64'h0000_0100_0000_0000);
            step(1'b0, x, y, x[19:0], y[19:0], e, e2);
            if (i >= 2) check($sformatf("alternate%0d", i), e, (i % 2 == 0));
        end

        // Reset for one edge while equal pairs are in flight.
        for (int i = 0; i < 4; i++) begin
            x = {$urandom, $urandom};
            step(1'b0, x, x, x[19:0], x[19:0], e, e2);
        end
        x = {$urandom, $urandom};
        step(1'b1, x, x, x[19:0], x[19:0], e, e2);
        check("midrst edge r", e, 1'b0);
        step(1'b0, x, x, x[19:0], x[19:0], e, e2);
        check("midrst edge r+1", e, 1'b0);
        step(1'b0, x, x, x[19:0], x[19:0], e, e2);
        step(1'b0, x, x, x[19:0], x[19:0], e, e2);
        check("midrst resume", e, 1'b1);

        // Narrow instance: only bit 19 differs, then an equal pair.
        x2 = 20'h0_A5C3;
        step(1'b0, x, x, x2 ^ 20'h8_0000, x2, e, e2);
        step(1'b0, x, x, x2, x2, e, e2);
        step(1'b0, x, x, x2, x2, e, e2);
        check("w20 bit19 diff", e2, 1'b0);
        step(1'b0, x, x, x2, x2, e, e2);
        check("w20 equal", e2, 1'b1);

        // Random soak: ~50% equal, ~25% single-bit difference, ~25% random.
        for (int i = 0; i < 500; i++) begin
            x   = {$urandom, $urandom};
            x2  = x[63:44];
            sel = $urandom_range(3);
            if (sel < 2) begin
                y  = x;
                y2 = x2;
            end else if (sel == 2) begin
                y  = x ^ (64'h1 << $urandom_range(63));
                y2 = x2 ^ (20'h1 << $urandom_range(19));
            end else begin
                y  = {$urandom, $urandom};
                y2 = 20'($urandom);
            end
            step(1'b0, x, y, x2, y2, e, e2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
